regbank_wr_arbiter: RTL and testbench
=====================================

# regbank_wr_arbiter

Write-port controller for the 32-entry register bank. It owns the bank's single write port (`RgW`/`wrA`/`wrD`). After reset it sequences a zero-fill of every register. It then shares the port between two writeback requesters, A (ALU result) and B (load result), using round-robin arbitration and a valid/ready handshake. It sits between the execute/memory stages and the register bank, and is the only driver of the bank's write inputs.

## Interface
Parameters:
- `NREG`, 32: number of registers to zero-fill.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: write data width.

Ports:
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  requester A has a write pending.
- `a_addr`  in  ADDR_W  requester A destination register.
- `a_data`  in  DATA_W  requester A write data.
- `a_ready`  out  1  A's request is accepted this cycle.
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same as the A ports, for requester B.
- `RgW`  out  1  registered write enable to the bank.
- `wrA`  out  ADDR_W  registered write address to the bank.
- `wrD`  out  DATA_W  registered write data to the bank.
- `busy`  out  1  high while the zero-fill is in progress.

## Operation
- States:
  - CLEAR (entered on reset).
  - RUN.
- Reset (`rst`=0, asynchronous) sets:
  - state=CLEAR, `clr_cnt`=0, `prio`=A.
  - `RgW`=0, `wrA`=0, `wrD`=0.
  - `busy`=1, `a_ready`=0, `b_ready`=0.
- CLEAR:
  - Each edge registers `RgW`=1, `wrA`=`clr_cnt`, `wrD`=0, then increments `clr_cnt`.
  - On the edge that issues `wrA`=NREG-1, state moves to RUN.
  - `a_ready` and `b_ready` are held 0; requester valids are ignored.
- RUN, ready logic (combinational from state, valids and `prio`):
  - `a_ready` = `a_valid` & (!`b_valid` | `prio`==A).
  - `b_ready` = `b_valid` & (!`a_valid` | `prio`==B).
  - At most one ready is high in any cycle.
- RUN, write path:
  - On an edge where a requester is accepted (valid & ready), that requester's addr/data are registered onto `wrA`/`wrD` with `RgW`=1.
  - On an edge with no acceptance, `RgW`=0 and `wrA`/`wrD` hold their values.
- RUN, priority:
  - After a grant to X, `prio` moves to the other requester.
  - With no grant, `prio` is unchanged.
- Requesters must hold valid, addr and data stable until ready is seen; valid may not be withdrawn before acceptance.
- Both requesters targeting the same address are serialized in grant order, so the later grant's data ends up in the register.
- `busy` = (state==CLEAR).
- Reset asserted mid-CLEAR or mid-RUN aborts immediately. Any pending request is dropped (not acknowledged). A full zero-fill restarts after `rst` deasserts.

## Timing
- Zero-fill takes exactly NREG cycles:
  - `RgW` is high for edges 1..NREG after `rst` deasserts.
  - `busy` falls on edge NREG.
  - The first ready is possible in the cycle after edge NREG.
- Write latency is 1 cycle: a request accepted at edge N is presented on `RgW`/`wrA`/`wrD` during cycle N+1 and written into the bank at edge N+1.
- Throughput is one write per cycle sustained. Under continuous contention A and B alternate.
- A combinational path runs from valid to ready. There is no path from ready to valid inside the block.

## Configuration
- `REGBANK_R0_PROTECT_EN` defined:
  - An accepted request with addr=0 completes its handshake normally and advances `prio`.
  - The registered `RgW` stays 0 for that cycle, so r0 is never written after the zero-fill.
  - The zero-fill itself still writes r0.
- `REGBANK_R0_PROTECT_EN` undefined: writes to addr 0 pass through like any other address.

## Test plan
- Reset release, no requests -> `RgW`=1 with `wrA` stepping 0..31 and `wrD`=0 over 32 cycles; `busy` falls at edge 32; readies are 0 throughout CLEAR.
- After CLEAR, A only: addr=5, data=0xDEADBEEF -> `a_ready`=1 in the same cycle; next cycle `RgW`=1, `wrA`=5, `wrD`=0xDEADBEEF; `prio`=B.
- A and B valid continuously for 4 cycles, A addr=3/data=0x11, B addr=3/data=0x22 -> grants in order A, B, A, B with `RgW` high every cycle; no cycle has both readies high.
- Both valid with `prio`=B -> B is granted first; A is held with `a_ready`=0 and granted the following cycle.
- `rst` pulsed low at fill cycle 10, then during a pending B request -> outputs return to reset values immediately; the fill restarts at `wrA`=0; B is never acknowledged.
- A addr=0, data=0x55 -> with `REGBANK_R0_PROTECT_EN`: `a_ready`=1 and `RgW` stays 0; without the macro: `RgW`=1, `wrA`=0, `wrD`=0x55.

Source files
------------

// File: rtl/regbank_wr_arbiter.sv
// Register-bank write-port owner: zero-fills NREG regs after reset, then round-robins A/B writebacks (REGBANK_R0_PROTECT_EN blocks r0 writes).
// Latency: accepted request appears on RgW/wrA/wrD one cycle later; zero-fill takes NREG cycles.
// Backpressure: ready is combinational from valid; requesters hold valid/addr/data until ready is seen.
module regbank_wr_arbiter #(
  parameter int NREG   = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              RgW,
  output logic [ADDR_W-1:0] wrA,
  output logic [DATA_W-1:0] wrD,
  output logic              busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              prio;
  logic              clr_last;
  logic              a_acc, b_acc, any_acc;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              grant_we;

  assign clr_last = (clr_cnt == ADDR_W'(NREG - 1));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state)
      CLEAR: busy = 1'b1;
      RUN: begin
        a_ready = a_valid & (!b_valid | (prio == PRIO_A));
        b_ready = b_valid & (!a_valid | (prio == PRIO_B));
      end
      default: busy = 1'b1;
    endcase
  end

  assign a_acc    = a_valid & a_ready;
  assign b_acc    = b_valid & b_ready;
  assign any_acc  = a_acc | b_acc;
  assign sel_addr = a_acc ? a_addr : b_addr;
  assign sel_data = a_acc ? a_data : b_data;

`ifdef REGBANK_R0_PROTECT_EN
  // Handshake still completes for r0; only the bank write is suppressed.
  assign grant_we = any_acc & (sel_addr != '0);
`else
  assign grant_we = any_acc;
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      clr_cnt <= '0;
      prio    <= PRIO_A;
      RgW     <= 1'b0;
      wrA     <= '0;
      wrD     <= '0;
    end else if (state == CLEAR) begin
      RgW     <= 1'b1;
      wrA     <= clr_cnt;
      wrD     <= '0;
      clr_cnt <= clr_cnt + 1'b1;
    end else begin
      RgW <= grant_we;
      if (any_acc) begin
        wrA <= sel_addr;
        wrD <= sel_data;
      end
      if (a_acc)      prio <= PRIO_B;
      else if (b_acc) prio <= PRIO_A;
    end
  end

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed bench for regbank_wr_arbiter: zero-fill, single grants, round-robin contention, reset abort, r0 write.
module tb_regbank_wr_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        RgW;
  logic [4:0]  wrA;
  logic [31:0] wrD;
  logic        busy;

  int checks = 0;
  int errors = 0;

  regbank_wr_arbiter #(.NREG(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clock   (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .b_ready (b_ready),
    .RgW     (RgW),
    .wrA     (wrA),
    .wrD     (wrD),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Release reset and walk the 32-cycle zero-fill; valids are raised for most of it and must be ignored.
  task automatic do_fill();
    rst = 1'b1;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hAAAA_0000;
    b_valid = 1'b1; b_addr = 5'd8; b_data = 32'hBBBB_0000;
    for (int i = 1; i <= 32; i++) begin
      cyc();
      check("fill_rgw",  32'(RgW),  32'(1));
      check("fill_wra",  32'(wrA),  32'(i - 1));
      check("fill_wrd",  wrD,       32'h0);
      check("fill_busy", 32'(busy), 32'(i < 32));
      if (i < 32) begin
        check("fill_a_rdy", 32'(a_ready), 32'(0));
        check("fill_b_rdy", 32'(b_ready), 32'(0));
      end
      if (i == 31) begin
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    #2;
    check("rst_rgw",   32'(RgW),     32'(0));
    check("rst_wra",   32'(wrA),     32'(0));
    check("rst_wrd",   wrD,          32'h0);
    check("rst_busy",  32'(busy),    32'(1));
    check("rst_a_rdy", 32'(a_ready), 32'(0));
    check("rst_b_rdy", 32'(b_ready), 32'(0));
    cyc();
    cyc();
    check("rst_hold_rgw", 32'(RgW), 32'(0));

    do_fill();

    // A alone: addr 5, 0xDEADBEEF
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    check("a1_a_rdy", 32'(a_ready), 32'(1));
    check("a1_b_rdy", 32'(b_ready), 32'(0));
    cyc();
    a_valid = 1'b0;
    check("a1_rgw", 32'(RgW), 32'(1));
    check("a1_wra", 32'(wrA), 32'(5));
    check("a1_wrd", wrD,      32'hDEAD_BEEF);
    cyc();
    check("idle_rgw", 32'(RgW), 32'(0));
    check("idle_wra", 32'(wrA), 32'(5));
    check("idle_wrd", wrD,      32'hDEAD_BEEF);

    // prio is B now: contention grants B first, A next cycle
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h22;
    #1;
    check("pb_b_rdy", 32'(b_ready), 32'(1));
    check("pb_a_rdy", 32'(a_ready), 32'(0));
    cyc();
    b_valid = 1'b0;
    check("pb_wrd_b", wrD, 32'h22);
    #1;
    check("pb_a_rdy2", 32'(a_ready), 32'(1));
    cyc();
    a_valid = 1'b0;
    check("pb_rgw_a", 32'(RgW), 32'(1));
    check("pb_wrd_a", wrD,      32'h11);
    check("pb_wra_a", 32'(wrA), 32'(3));

    // prio is B: a lone B grant returns it to A before the 4-cycle contention run
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    #1;
    check("b1_b_rdy", 32'(b_ready), 32'(1));
    cyc();
    b_valid = 1'b0;
    check("b1_wra", 32'(wrA), 32'(9));
    check("b1_wrd", wrD,      32'h99);

    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_a_rdy", 32'(a_ready), 32'(k % 2 == 0));
      check("rr_b_rdy", 32'(b_ready), 32'(k % 2 == 1));
      check("rr_excl",  32'(a_ready & b_ready), 32'(0));
      cyc();
      check("rr_rgw", 32'(RgW), 32'(1));
      check("rr_wra", 32'(wrA), 32'(3));
      check("rr_wrd", wrD, (k % 2 == 0) ? 32'h11 : 32'h22);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;

    // r0 write from A
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h55;
    #1;
    check("r0_a_rdy", 32'(a_ready), 32'(1));
    cyc();
    a_valid = 1'b0;
`ifdef REGBANK_R0_PROTECT_EN
    check("r0_rgw", 32'(RgW), 32'(0));
`else
    check("r0_rgw", 32'(RgW), 32'(1));
    check("r0_wra", 32'(wrA), 32'(0));
    check("r0_wrd", wrD,      32'h55);
`endif

    // Reset mid-fill at cycle 10
    rst = 1'b0;
    #1;
    cyc();
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) cyc();
    check("mid_wra10", 32'(wrA),  32'(9));
    check("mid_busy",  32'(busy), 32'(1));
    rst = 1'b0;
    #1;
    check("mid_rst_rgw",  32'(RgW),  32'(0));
    check("mid_rst_wra",  32'(wrA),  32'(0));
    check("mid_rst_busy", 32'(busy), 32'(1));
    cyc();
    do_fill();

    // Reset while a B request is pending
    b_valid = 1'b1; b_addr = 5'd12; b_data = 32'hCAFE_F00D;
    #1;
    check("pend_b_rdy", 32'(b_ready), 32'(1));
    rst = 1'b0;
    #1;
    check("pend_rst_b_rdy", 32'(b_ready), 32'(0));
    check("pend_rst_rgw",   32'(RgW),     32'(0));
    check("pend_rst_busy",  32'(busy),    32'(1));
    cyc();
    check("pend_hold_rgw", 32'(RgW), 32'(0));
    check("pend_hold_wrd", wrD,      32'h0);
    b_valid = 1'b0;
    rst = 1'b1;
    cyc();
    check("restart_rgw", 32'(RgW), 32'(1));
    check("restart_wra", 32'(wrA), 32'(0));
    check("restart_wrd", wrD,      32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
